// File: rtl/nyan_synth_pkg.sv
// Shared constants and types for the nyan_synth chiptune sequencer.
// A song step word holds {trigger, octave[1:0], note[2:0]} for one voice.
package nyan_synth_pkg;

    localparam int unsigned STEP_W   = 6;
    localparam int unsigned TRIG_BIT = 5;
    localparam int unsigned OCT_HI   = 4;
    localparam int unsigned OCT_LO   = 3;
    localparam int unsigned NOTE_HI  = 2;
    localparam int unsigned NOTE_LO  = 0;

    localparam logic [7:0] NOTE_INC [0:7] = '{
        8'd67, 8'd75, 8'd84, 8'd89, 8'd100, 8'd112, 8'd126, 8'd134
    };

    typedef struct packed {
        logic       trig;
        logic [1:0] oct;
        logic [2:0] note;
    } step_t;

    typedef enum logic {
        WAVE_SQUARE  = 1'b0,
        WAVE_PULSE25 = 1'b1
    } wave_e;

    function automatic step_t unpack_step(input logic [STEP_W-1:0] word);
        step_t s;
        s.trig = word[TRIG_BIT];
        s.oct  = word[OCT_HI:OCT_LO];
        s.note = word[NOTE_HI:NOTE_LO];
        return s;
    endfunction

    // Octave 3 folds onto octave 2 so the tap bits stay inside narrow accumulators.
    function automatic logic [1:0] eff_oct(input logic [1:0] oct);
        return (oct == 2'd3) ? 2'd2 : oct;
    endfunction

endpackage

// File: rtl/nyan_synth_voice.sv
// One square/pulse voice: phase accumulator, decaying envelope and waveform tap.
// Step fields latch on load; a trigger in the loaded word reloads the envelope.
module nyan_synth_voice
    import nyan_synth_pkg::*;
#(
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned VOL_W   = 6,
    parameter logic [2:0]  SHIFT   = 3'd2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_restart,
    input  logic              i_sample,
    input  logic              i_decay,
    input  logic              i_load,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_pulse25,
    output logic [VOL_W-1:0]  o_vol,
    output logic              o_wave
);

    logic [PHASE_W-1:0] r_phase;
    logic [VOL_W-1:0]   r_vol;
    logic [1:0]         r_oct;
    logic [2:0]         r_note;

    step_t      w_new;
    logic [1:0] w_oct;
    logic       w_b;
    logic       w_lo;

    assign w_new = unpack_step(i_step);
    assign w_oct = eff_oct(r_oct);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_vol   <= '0;
            r_oct   <= '0;
            r_note  <= '0;
        end else if (i_restart) begin
            r_phase <= '0;
            r_vol   <= '0;
            r_oct   <= '0;
            r_note  <= '0;
        end else begin
            if (i_sample)
                r_phase <= r_phase + PHASE_W'(NOTE_INC[r_note]);
            if (i_load) begin
                r_oct  <= w_new.oct;
                r_note <= w_new.note;
            end
            // A trigger wins over a coincident decay tick.
            if (i_load && w_new.trig)
                r_vol <= '1;
            else if (i_decay)
                r_vol <= r_vol - (r_vol >> SHIFT);
        end
    end

    always_comb begin
        w_b  = r_phase[PHASE_W-1];
        w_lo = r_phase[PHASE_W-2];
        case (w_oct)
            2'd1: begin
                w_b  = r_phase[PHASE_W-2];
                w_lo = r_phase[PHASE_W-3];
            end
            2'd2: begin
                w_b  = r_phase[PHASE_W-3];
                w_lo = r_phase[PHASE_W-4];
            end
            default: ;
        endcase
    end

    assign o_vol  = r_vol;
    assign o_wave = (wave_e'(i_pulse25) == WAVE_PULSE25) ? (w_b & w_lo) : w_b;

endmodule

// File: rtl/nyan_synth.sv
// Multi-voice chiptune sequencer: song stepping on tick strobes, voice mix,
// and a first-order PWM DAC whose carry is the output pin.
module nyan_synth
    import nyan_synth_pkg::*;
#(
    parameter int unsigned VOICES         = 2,
    parameter int unsigned SONG_LEN       = 288,
    parameter int unsigned TICKS_PER_STEP = 6,
    parameter int unsigned PHASE_W        = 16,
    parameter int unsigned VOL_W          = 6,
    parameter logic [3*VOICES-1:0] DECAY_SHIFTS = {3'd3, 3'd2},
    localparam int unsigned AW = $clog2(SONG_LEN),
    localparam int unsigned MW = VOL_W + $clog2(VOICES)
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_stb,
    input  logic                     tick_stb,
    input  logic                     run,
    input  logic                     restart,
    input  logic [VOICES-1:0]        mute,
    input  logic [VOICES-1:0]        pulse25,
    output logic [AW-1:0]            song_addr,
    input  logic [STEP_W*VOICES-1:0] song_data,
    output logic                     step_stb,
    output logic [MW-1:0]            sample,
    output logic                     pwm_out
);

    localparam int unsigned TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    logic [TW-1:0] r_tick_ctr;
    logic [AW-1:0] r_song_addr;
    logic          r_load_pending;
    logic          r_step_stb;
    logic [MW-1:0] r_accum;
    logic          r_pwm;

    logic             w_tick;
    logic             w_adv;
    logic             w_decay;
    logic             w_load;
    logic             w_sample;
    logic [MW-1:0]    w_mix;
    logic [MW:0]      w_pwm_sum;
    logic [VOL_W-1:0] w_vol  [VOICES];
    logic [VOICES-1:0] w_wave;

    assign w_tick   = run & tick_stb;
    assign w_adv    = w_tick & (r_tick_ctr == TW'(TICKS_PER_STEP - 1));
    assign w_decay  = w_tick & ~w_adv & ~restart;
    assign w_load   = run & r_load_pending & ~restart;
    assign w_sample = run & sample_stb & ~restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_ctr     <= '0;
            r_song_addr    <= AW'(SONG_LEN - 1);
            r_load_pending <= 1'b0;
            r_step_stb     <= 1'b0;
        end else if (restart) begin
            r_tick_ctr     <= '0;
            r_song_addr    <= AW'(SONG_LEN - 1);
            r_load_pending <= 1'b0;
            r_step_stb     <= 1'b0;
        end else begin
            r_step_stb <= w_load;
            if (w_adv) begin
                r_tick_ctr     <= '0;
                r_song_addr    <= (r_song_addr == AW'(SONG_LEN - 1)) ? '0 : r_song_addr + 1'b1;
                r_load_pending <= 1'b1;
            end else begin
                if (w_tick)
                    r_tick_ctr <= r_tick_ctr + 1'b1;
                if (w_load)
                    r_load_pending <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        nyan_synth_voice #(
            .PHASE_W (PHASE_W),
            .VOL_W   (VOL_W),
            .SHIFT   (DECAY_SHIFTS[3*g +: 3])
        ) u_voice (
            .clk       (clk),
            .rst       (reset),
            .i_restart (restart),
            .i_sample  (w_sample),
            .i_decay   (w_decay),
            .i_load    (w_load),
            .i_step    (song_data[STEP_W*g +: STEP_W]),
            .i_pulse25 (pulse25[g]),
            .o_vol     (w_vol[g]),
            .o_wave    (w_wave[g])
        );
    end

    always_comb begin
        w_mix = '0;
        for (int unsigned v = 0; v < VOICES; v++) begin
            if (w_wave[v] && !mute[v])
                w_mix = w_mix + MW'(w_vol[v]);
        end
    end

    // The adder carry is the 1-bit DAC output; accum keeps running across restart.
    assign w_pwm_sum = {1'b0, r_accum} + {1'b0, w_mix};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_accum <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_accum <= w_pwm_sum[MW-1:0];
            r_pwm   <= w_pwm_sum[MW];
        end
    end

    assign song_addr = r_song_addr;
    assign step_stb  = r_step_stb;
    assign sample    = w_mix;
    assign pwm_out   = r_pwm;

endmodule

// File: tb/tb_nyan_synth.sv
// Self-checking bench for nyan_synth: directed vector table, hand sequences and
// a randomized run against a behavioural model of the sequencer and mixer.
module tb_nyan_synth;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_stb, tick_stb, run, restart;
    logic [1:0]  mute, pulse25;
    logic [8:0]  song_addr;
    logic [11:0] song_data;
    logic        step_stb;
    logic [6:0]  sample;
    logic        pwm_out;

    logic        w_tick;
    logic [1:0]  w_addr;
    logic [11:0] w_data;
    logic        w_stb;
    logic [6:0]  w_sample;
    logic        w_pwm;

    logic [11:0] rom [0:287];

    int total = 0;
    int bad   = 0;

    int m_addr, m_tc, m_accum;
    bit m_pend, m_stb, m_pwm;
    int m_phase [2];
    int m_vol   [2];
    int m_oct   [2];
    int m_note  [2];
    int inc_tbl [8] = '{67, 75, 84, 89, 100, 112, 126, 134};
    int sh_tbl  [2] = '{2, 3};

    typedef struct {
        bit       tick;
        bit [1:0] mute;
        int       e_addr;
        bit       e_stb;
        int       e_sample;
    } vec_t;
    vec_t tbl [18];

    always #5 clk = ~clk;

    assign song_data = rom[song_addr];
    assign w_data    = '0;

    nyan_synth dut (
        .clk        (clk),
        .reset      (rst),
        .sample_stb (sample_stb),
        .tick_stb   (tick_stb),
        .run        (run),
        .restart    (restart),
        .mute       (mute),
        .pulse25    (pulse25),
        .song_addr  (song_addr),
        .song_data  (song_data),
        .step_stb   (step_stb),
        .sample     (sample),
        .pwm_out    (pwm_out)
    );

    nyan_synth #(
        .SONG_LEN       (4),
        .TICKS_PER_STEP (2)
    ) dut_w (
        .clk        (clk),
        .reset      (rst),
        .sample_stb (1'b0),
        .tick_stb   (w_tick),
        .run        (1'b1),
        .restart    (1'b0),
        .mute       (2'b00),
        .pulse25    (2'b00),
        .song_addr  (w_addr),
        .song_data  (w_data),
        .step_stb   (w_stb),
        .sample     (w_sample),
        .pwm_out    (w_pwm)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_sample();
        int s;
        s = 0;
        for (int v = 0; v < 2; v++) begin
            int o, bp, b, lo, w;
            o  = (m_oct[v] > 2) ? 2 : m_oct[v];
            bp = 15 - o;
            b  = (m_phase[v] >> bp) & 1;
            lo = (m_phase[v] >> (bp - 1)) & 1;
            w  = pulse25[v] ? (b & lo) : b;
            if (w != 0 && !mute[v])
                s += m_vol[v];
        end
        return s;
    endfunction

    task automatic model_seq_clear();
        m_addr = 287;
        m_tc   = 0;
        m_pend = 0;
        m_stb  = 0;
        for (int v = 0; v < 2; v++) begin
            m_phase[v] = 0;
            m_vol[v]   = 0;
            m_oct[v]   = 0;
            m_note[v]  = 0;
        end
    endtask

    task automatic model_reset();
        model_seq_clear();
        m_accum = 0;
        m_pwm   = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int tot, field;
        bit adv, dec, load;
        if (rst) begin
            model_reset();
            return;
        end
        tot     = m_accum + m_sample();
        m_pwm   = (tot >= 128);
        m_accum = tot % 128;
        if (restart) begin
            model_seq_clear();
            return;
        end
        load  = run && m_pend;
        adv   = run && tick_stb && (m_tc == 5);
        dec   = run && tick_stb && !adv;
        m_stb = load;
        for (int v = 0; v < 2; v++) begin
            field = (rom[m_addr] >> (6 * v)) & 63;
            if (run && sample_stb)
                m_phase[v] = (m_phase[v] + inc_tbl[m_note[v]]) % 65536;
            if (load && (field >= 32))
                m_vol[v] = 63;
            else if (dec)
                m_vol[v] = m_vol[v] - (m_vol[v] >> sh_tbl[v]);
            if (load) begin
                m_oct[v]  = (field >> 3) & 3;
                m_note[v] = field & 7;
            end
        end
        if (adv) begin
            m_tc   = 0;
            m_addr = (m_addr + 1) % 288;
            m_pend = 1;
        end else begin
            if (dec)
                m_tc++;
            if (load)
                m_pend = 0;
        end
    endtask

    task automatic check_model();
        chk("addr", song_addr, m_addr);
        chk("step_stb", step_stb, m_stb);
        chk("sample", sample, m_sample());
        chk("pwm", pwm_out, m_pwm);
    endtask

    task automatic cyc(input bit s, input bit t, input bit r, input bit rs,
                       input bit [1:0] mu, input bit [1:0] pu);
        sample_stb = s;
        tick_stb   = t;
        run        = r;
        restart    = rs;
        mute       = mu;
        pulse25    = pu;
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        for (int i = 0; i < 288; i++)
            rom[i] = 12'($urandom);
        rom[0] = 12'h924;
        rom[1] = 12'h124;

        tbl[0]  = '{1, 2'b00, 287, 0, 0};
        tbl[1]  = '{1, 2'b00, 287, 0, 0};
        tbl[2]  = '{0, 2'b00, 287, 0, 0};
        tbl[3]  = '{1, 2'b00, 287, 0, 0};
        tbl[4]  = '{1, 2'b00, 287, 0, 0};
        tbl[5]  = '{1, 2'b00, 287, 0, 0};
        tbl[6]  = '{1, 2'b00, 0,   0, 0};
        tbl[7]  = '{0, 2'b00, 0,   1, 126};
        tbl[8]  = '{1, 2'b00, 0,   0, 104};
        tbl[9]  = '{1, 2'b00, 0,   0, 85};
        tbl[10] = '{0, 2'b01, 0,   0, 49};
        tbl[11] = '{0, 2'b10, 0,   0, 36};
        tbl[12] = '{0, 2'b11, 0,   0, 0};
        tbl[13] = '{1, 2'b00, 0,   0, 70};
        tbl[14] = '{1, 2'b00, 0,   0, 59};
        tbl[15] = '{1, 2'b00, 0,   0, 50};
        tbl[16] = '{1, 2'b00, 1,   0, 50};
        tbl[17] = '{1, 2'b00, 1,   1, 93};

        rst = 1'b1;
        sample_stb = 0; tick_stb = 0; run = 0; restart = 0;
        mute = 2'b00; pulse25 = 2'b00; w_tick = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", song_addr, 287);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_sample", sample, 0);
        chk("rst_stb", step_stb, 0);
        rst = 1'b0;

        // Push both phases past half scale so the square waves read high.
        repeat (490) cyc(1, 0, 1, 0, 2'b00, 2'b00);

        for (int i = 0; i < 18; i++) begin
            cyc(0, tbl[i].tick, 1, 0, tbl[i].mute, 2'b00);
            chk($sformatf("vec%0d_addr", i), song_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_stb", i), step_stb, tbl[i].e_stb);
            chk($sformatf("vec%0d_sample", i), sample, tbl[i].e_sample);
        end

        // Restart in the cycle where a load is pending.
        repeat (5) cyc(0, 1, 1, 0, 2'b00, 2'b00);
        chk("pre_restart_addr", song_addr, 2);
        cyc(0, 0, 1, 1, 2'b00, 2'b00);
        chk("restart_addr", song_addr, 287);
        chk("restart_stb", step_stb, 0);
        chk("restart_sample", sample, 0);
        cyc(0, 0, 1, 0, 2'b00, 2'b00);
        chk("restart_no_stb", step_stb, 0);

        // Phase and waveform: voice notes 4 (inc 100), octave 0.
        repeat (6) cyc(0, 1, 1, 0, 2'b00, 2'b00);
        cyc(0, 0, 1, 0, 2'b00, 2'b00);
        chk("load_stb", step_stb, 1);
        chk("load_phase0", sample, 0);
        repeat (10) cyc(1, 0, 1, 0, 2'b00, 2'b00);
        chk("ph1000_sq", sample, 0);
        repeat (318) cyc(1, 0, 1, 0, 2'b00, 2'b00);
        chk("ph8000_sq", sample, 126);
        cyc(0, 0, 1, 0, 2'b00, 2'b11);
        chk("ph8000_p25", sample, 0);
        repeat (164) cyc(1, 0, 1, 0, 2'b00, 2'b11);
        chk("phC000_p25", sample, 126);
        cyc(0, 0, 1, 0, 2'b00, 2'b00);
        chk("phC000_sq", sample, 126);

        // run low freezes everything despite strobes.
        repeat (20) cyc(1, 1, 0, 0, 2'b00, 2'b00);
        chk("freeze_addr", song_addr, 0);
        chk("freeze_sample", sample, 126);
        cyc(0, 1, 1, 0, 2'b00, 2'b00);
        chk("unfreeze_decay", sample, 104);

        // Asynchronous reset mid-step.
        repeat (3) cyc(1, 1, 1, 0, 2'b00, 2'b00);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_addr", song_addr, 287);
        chk("async_sample", sample, 0);
        chk("async_pwm", pwm_out, 0);
        chk("async_stb", step_stb, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 2) == 0, ($urandom % 4) == 0, ($urandom % 10) != 0,
                ($urandom % 300) == 0, 2'($urandom), 2'($urandom));
        end

        repeat (3) cyc(1, 1, 1, 0, 2'b11, 2'($urandom));
        chk("mute_sample", sample, 0);
        chk("mute_pwm", pwm_out, 0);

        // Short song wrap on the second instance.
        chk("wrap_init", w_addr, 3);
        for (int k = 1; k <= 10; k++) begin
            w_tick = 1'b1;
            cyc(0, 0, 1, 0, 2'b00, 2'b00);
            chk($sformatf("wrap%0d_hold", k), w_addr, (k + 2) % 4);
            cyc(0, 0, 1, 0, 2'b00, 2'b00);
            chk($sformatf("wrap%0d_addr", k), w_addr, (k - 1) % 4);
        end
        w_tick = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
